snax_alu_ctrl: RTL and testbench
================================

# snax_alu_ctrl

Run-level sequencer for the SNAX ALU processing element. It latches an operation mode and a transfer count at a start command, and drives the PE's `acc_ready` gate and `alu_config` select for the length of the run. It counts completed result handshakes and, once the programmed count is reached, closes the gate and pulses `done_o`. It sits between the accelerator CSR front-end and the PE array and also reports a per-run busy-cycle counter.

## Interface
- `LenWidth`, default 32: width of the transfer count.
- `PerfWidth`, default 32: width of the busy-cycle counter.

Ports:
- `clk_i`  in  1  clock. There is one clock.
- `rst_ni`  in  1  reset. Asynchronous, active-low.
- `start_i`  in  1  single-cycle start command. Accepted only in IDLE.
- `abort_i`  in  1  synchronous abort. Highest priority.
- `cfg_mode_i`  in  2  ALU op: 0 add, 1 sub, 2 mul, 3 xor. Sampled on an accepted start.
- `cfg_len_i`  in  LenWidth  number of result transfers in the run. Sampled on an accepted start.
- `pe_c_valid_i`  in  1  PE result valid.
- `pe_c_ready_i`  in  1  downstream ready for the PE result.
- `acc_ready_o`  out  1  gate to the PE; high only in RUN.
- `alu_config_o`  out  2  latched op select to the PE.
- `busy_o`  out  1  high whenever state ≠ IDLE.
- `done_o`  out  1  one-cycle completion pulse.
- `xfer_cnt_o`  out  LenWidth  transfers completed in the current or last run.
- `perf_cycles_o`  out  PerfWidth  cycles spent in RUN in the current or last run.

## Operation
- **States.** The FSM has three states: IDLE, RUN and DONE. Reset state is IDLE.
- **Transfer.** A transfer is counted in a cycle where state = RUN and `pe_c_valid_i` and `pe_c_ready_i` are both high.
- **IDLE → RUN.** On `start_i` with `cfg_len_i` ≠ 0, the block:
  - latches `cfg_mode_i` into `alu_config_o` and `cfg_len_i` into the length register;
  - clears `xfer_cnt_o` and `perf_cycles_o`.
- **IDLE → DONE.** On `start_i` with `cfg_len_i` = 0, the block latches the mode, clears both counters, and never asserts `acc_ready_o`.
- **RUN → DONE.** Taken on the transfer where `xfer_cnt_o` = len − 1; `xfer_cnt_o` becomes len.
- **RUN → RUN.** On any other transfer, `xfer_cnt_o` increments by 1.
- **DONE → IDLE.** Unconditional after one cycle.
- **Busy-cycle counter.** `perf_cycles_o` increments every cycle spent in RUN, including the final cycle, and saturates at all-ones (no wrap).
- **Held values.** `alu_config_o` is held constant from the accepted start until the next accepted start. Both counters hold their values in DONE and IDLE until the next accepted start.
- **Ignored starts.** `start_i` in RUN or DONE is ignored; no state or register changes.
- **Abort.** `abort_i` in any state forces IDLE on the next edge and leaves counters and `alu_config_o` holding their current values.
  - No `done_o` is generated.
  - `abort_i` together with `start_i` in IDLE: abort wins, the start is dropped, and no register is updated.
- **Output decode.** `acc_ready_o` = (state == RUN), `done_o` = (state == DONE) and `busy_o` = (state ≠ IDLE), all decoded from the registered state only, with no combinational path from inputs.

## Timing
- **Reset values.** All outputs are 0 at reset: `acc_ready_o`, `alu_config_o`, `busy_o`, `done_o`, `xfer_cnt_o` and `perf_cycles_o`. Asserting `rst_ni` low mid-run returns the block to IDLE immediately and asynchronously.
- **Start latency.** With start accepted in cycle t:
  - `busy_o`, `acc_ready_o` and the new `alu_config_o` are visible from t+1;
  - for len = 0, `done_o` is high in t+1 and `busy_o` is low in t+2.
- **Completion latency.** With the last transfer in cycle k:
  - `acc_ready_o` is low in k+1, so the PE cannot produce a len+1-th transfer;
  - `done_o` is high in k+1 only;
  - `busy_o` is low from k+2;
  - a new start is accepted from k+2.
- **Stall-free run length.** With `pe_c_valid_i` and `pe_c_ready_i` held high, a run of len N occupies exactly N RUN cycles and `perf_cycles_o` = N.
- **Stalls.** Cycles in RUN without a transfer count toward `perf_cycles_o` but not toward `xfer_cnt_o`.
- **Count boundary.** A maximum-length count (all-ones) must complete without overflow. Only equality with len − 1 is compared; `xfer_cnt_o` never exceeds len.

## Test plan
- **Reset check.** Apply reset, then start with mode = 2, len = 4, valid and ready held high → all outputs 0 out of reset; `alu_config_o` = 2 and `acc_ready_o` high for exactly 4 cycles; `done_o` a single pulse one cycle after the 4th transfer; `xfer_cnt_o` = 4, `perf_cycles_o` = 4.
- **Backpressure.** Mode = 1, len = 3, `pe_c_ready_i` toggling 1,0,0,1,0,1 → exactly 3 transfers counted; `perf_cycles_o` = 6; `acc_ready_o` low the cycle after the 3rd transfer.
- **Zero length.** Start with len = 0 → `done_o` at t+1; `acc_ready_o` never high; `xfer_cnt_o` = 0; `busy_o` high for one cycle.
- **Abort mid-run.** Len = 10, abort after 5 transfers → IDLE the next cycle with no `done_o`; `xfer_cnt_o` = 5 holds; a simultaneous abort + start in IDLE stays IDLE with registers unchanged.
- **Ignored start.** Start pulses in RUN and DONE with a different mode and len → no effect on `alu_config_o`, the count or run length; a start in the cycle after DONE is accepted.
- **Asynchronous reset mid-run.** Assert `rst_ni` mid-run between clock edges → outputs go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/snax_alu_ctrl.sv
// Run-level sequencer for the SNAX ALU PE: gates acc_ready for a programmed
// number of result handshakes, then pulses done and reports a busy-cycle count.
module snax_alu_ctrl #(
   parameter int unsigned LenWidth  = 32,
   parameter int unsigned PerfWidth = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 start_i,
   input  logic                 abort_i,
   input  logic [1:0]           cfg_mode_i,
   input  logic [LenWidth-1:0]  cfg_len_i,
   input  logic                 pe_c_valid_i,
   input  logic                 pe_c_ready_i,
   output logic                 acc_ready_o,
   output logic [1:0]           alu_config_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [LenWidth-1:0]  xfer_cnt_o,
   output logic [PerfWidth-1:0] perf_cycles_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic [1:0]           mode_q;
   logic [LenWidth-1:0]  len_q;
   logic [LenWidth-1:0]  xfer_cnt_q;
   logic [PerfWidth-1:0] perf_q;

   logic accept;
   logic xfer;
   logic last_xfer;

   // Abort outranks everything, including a start arriving in the same cycle.
   assign accept    = (state_q == IDLE) && start_i && !abort_i;
   assign xfer      = (state_q == RUN) && pe_c_valid_i && pe_c_ready_i;
   assign last_xfer = xfer && (xfer_cnt_q == len_q - LenWidth'(1));

   // NOTE: every output of a combinational block gets a default first so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      if (abort_i) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE:    if (start_i) state_d = (cfg_len_i == '0) ? DONE : RUN;
            RUN:     if (last_xfer) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mode_q     <= '0;
         len_q      <= '0;
         xfer_cnt_q <= '0;
         perf_q     <= '0;
      end else if (accept) begin
         mode_q     <= cfg_mode_i;
         len_q      <= cfg_len_i;
         xfer_cnt_q <= '0;
         perf_q     <= '0;
      end else if (state_q == RUN && !abort_i) begin
         if (xfer) xfer_cnt_q <= xfer_cnt_q + LenWidth'(1);
         // Saturate rather than wrap so long stalled runs still read sensibly.
         if (perf_q != '1) perf_q <= perf_q + PerfWidth'(1);
      end
   end

   assign acc_ready_o   = (state_q == RUN);
   assign done_o        = (state_q == DONE);
   assign busy_o        = (state_q != IDLE);
   assign alu_config_o  = mode_q;
   assign xfer_cnt_o    = xfer_cnt_q;
   assign perf_cycles_o = perf_q;

endmodule

// File: tb/tb_snax_alu_ctrl.sv
// Self-checking bench for snax_alu_ctrl: directed scenarios plus random runs
// whose expectations come from counting handshakes in the driven stimulus.
module tb_snax_alu_ctrl;

   localparam int unsigned LenWidth  = 8;
   localparam int unsigned PerfWidth = 5;
   localparam int          PerfMax   = (1 << PerfWidth) - 1;

   logic                 clk_i = 1'b0;
   logic                 rst_ni;
   logic                 start_i;
   logic                 abort_i;
   logic [1:0]           cfg_mode_i;
   logic [LenWidth-1:0]  cfg_len_i;
   logic                 pe_c_valid_i;
   logic                 pe_c_ready_i;
   logic                 acc_ready_o;
   logic [1:0]           alu_config_o;
   logic                 busy_o;
   logic                 done_o;
   logic [LenWidth-1:0]  xfer_cnt_o;
   logic [PerfWidth-1:0] perf_cycles_o;

   int n_cmp  = 0;
   int n_fail = 0;

   // Ready pattern used by pattern-driven runs (valid held high).
   bit pat[$];

   snax_alu_ctrl #(.LenWidth(LenWidth), .PerfWidth(PerfWidth)) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .start_i      (start_i),
      .abort_i      (abort_i),
      .cfg_mode_i   (cfg_mode_i),
      .cfg_len_i    (cfg_len_i),
      .pe_c_valid_i (pe_c_valid_i),
      .pe_c_ready_i (pe_c_ready_i),
      .acc_ready_o  (acc_ready_o),
      .alu_config_o (alu_config_o),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .xfer_cnt_o   (xfer_cnt_o),
      .perf_cycles_o(perf_cycles_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   function automatic int sat(input int c);
      return (c > PerfMax) ? PerfMax : c;
   endfunction

   task automatic check_all(input string tag, input bit acc, input bit done, input bit busy,
                            input int mode, input int cnt, input int perf);
      check({tag, ".acc_ready"},   64'(acc_ready_o),   64'(acc));
      check({tag, ".done"},        64'(done_o),        64'(done));
      check({tag, ".busy"},        64'(busy_o),        64'(busy));
      check({tag, ".alu_config"},  64'(alu_config_o),  64'(mode));
      check({tag, ".xfer_cnt"},    64'(xfer_cnt_o),    64'(cnt));
      check({tag, ".perf_cycles"}, 64'(perf_cycles_o), 64'(perf));
   endtask

   // kind: 0 = valid/ready held high, 1 = random handshakes, 2 = ready from pat.
   // stray: inject ignored start pulses with a different mode/len in RUN and DONE.
   task automatic run(input string tag, input int mode, input int len, input int kind, input bit stray);
      int xfers  = 0;
      int cycles = 0;
      start_i    = 1'b1;
      cfg_mode_i = 2'(mode);
      cfg_len_i  = LenWidth'(len);
      pe_c_valid_i = 1'b0;
      pe_c_ready_i = 1'b0;
      tick();
      start_i = 1'b0;
      if (len == 0) begin
         check_all({tag, ".zero_t1"}, 1'b0, 1'b1, 1'b1, mode, 0, 0);
         pe_c_valid_i = 1'b1;
         pe_c_ready_i = 1'b1;
         tick();
         check_all({tag, ".zero_t2"}, 1'b0, 1'b0, 1'b0, mode, 0, 0);
         pe_c_valid_i = 1'b0;
         pe_c_ready_i = 1'b0;
         return;
      end
      while (xfers < len) begin
         if (cycles > 2000) begin
            check({tag, ".timeout"}, 64'(xfers), 64'(len));
            return;
         end
         check_all({tag, ".run"}, 1'b1, 1'b0, 1'b1, mode, xfers, sat(cycles));
         case (kind)
            0: begin pe_c_valid_i = 1'b1; pe_c_ready_i = 1'b1; end
            1: begin
               pe_c_valid_i = ($urandom_range(0, 9) < 7);
               pe_c_ready_i = ($urandom_range(0, 9) < 6);
            end
            default: begin
               pe_c_valid_i = 1'b1;
               pe_c_ready_i = (cycles < pat.size()) ? pat[cycles] : 1'b1;
            end
         endcase
         if (stray && (cycles % 3 == 1)) begin
            start_i    = 1'b1;
            cfg_mode_i = 2'(~mode);
            cfg_len_i  = LenWidth'(len + 5);
         end else begin
            start_i = 1'b0;
         end
         if (pe_c_valid_i && pe_c_ready_i) xfers++;
         cycles++;
         tick();
      end
      // Completion cycle: gate closed, done pulse; handshake inputs stay high.
      check_all({tag, ".done"}, 1'b0, 1'b1, 1'b1, mode, len, sat(cycles));
      pe_c_valid_i = 1'b1;
      pe_c_ready_i = 1'b1;
      start_i      = stray;
      cfg_mode_i   = 2'(~mode);
      cfg_len_i    = LenWidth'(len + 1);
      tick();
      check_all({tag, ".idle"}, 1'b0, 1'b0, 1'b0, mode, len, sat(cycles));
      start_i      = 1'b0;
      pe_c_valid_i = 1'b0;
      pe_c_ready_i = 1'b0;
   endtask

   initial begin
      rst_ni       = 1'b0;
      start_i      = 1'b0;
      abort_i      = 1'b0;
      cfg_mode_i   = 2'd0;
      cfg_len_i    = '0;
      pe_c_valid_i = 1'b0;
      pe_c_ready_i = 1'b0;

      // Reset state.
      #12;
      check_all("reset", 1'b0, 1'b0, 1'b0, 0, 0, 0);
      rst_ni = 1'b1;
      tick();
      check_all("post_reset", 1'b0, 1'b0, 1'b0, 0, 0, 0);

      // Stall-free run, mode 2, len 4.
      run("basic", 2, 4, 0, 1'b0);

      // Backpressure: ready 1,0,0,1,0,1 gives 3 transfers in 6 RUN cycles.
      pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      run("bp", 1, 3, 2, 1'b0);

      // Zero length.
      run("zero", 3, 0, 0, 1'b0);

      // Ignored starts in RUN and DONE, then back-to-back accepted start.
      run("stray", 1, 6, 0, 1'b1);
      run("b2b", 0, 2, 0, 1'b0);

      // Abort after 5 transfers of a 10-transfer run; handshake present in the
      // abort cycle must not be counted.
      start_i    = 1'b1;
      cfg_mode_i = 2'd3;
      cfg_len_i  = LenWidth'(10);
      tick();
      start_i      = 1'b0;
      pe_c_valid_i = 1'b1;
      pe_c_ready_i = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      check_all("abort.pre", 1'b1, 1'b0, 1'b1, 3, 5, 5);
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      check_all("abort.t1", 1'b0, 1'b0, 1'b0, 3, 5, 5);
      tick();
      check_all("abort.t2", 1'b0, 1'b0, 1'b0, 3, 5, 5);
      // Abort together with start in IDLE: start dropped.
      abort_i    = 1'b1;
      start_i    = 1'b1;
      cfg_mode_i = 2'd1;
      cfg_len_i  = LenWidth'(7);
      tick();
      abort_i = 1'b0;
      start_i = 1'b0;
      pe_c_valid_i = 1'b0;
      pe_c_ready_i = 1'b0;
      check_all("abort_start", 1'b0, 1'b0, 1'b0, 3, 5, 5);
      tick();
      check_all("abort_start.t2", 1'b0, 1'b0, 1'b0, 3, 5, 5);

      // Maximum-length count; busy counter saturates along the way.
      run("maxlen", 2, (1 << LenWidth) - 1, 0, 1'b0);

      // Random runs.
      for (int r = 0; r < 8; r++) begin
         run("rand", int'($urandom_range(0, 3)), int'($urandom_range(0, 20)), 1,
             bit'($urandom_range(0, 1)));
      end

      // Asynchronous reset between clock edges mid-run.
      start_i    = 1'b1;
      cfg_mode_i = 2'd2;
      cfg_len_i  = LenWidth'(8);
      tick();
      start_i      = 1'b0;
      pe_c_valid_i = 1'b1;
      pe_c_ready_i = 1'b1;
      tick();
      tick();
      check_all("areset.pre", 1'b1, 1'b0, 1'b1, 2, 2, 2);
      #2;
      rst_ni = 1'b0;
      #1;
      check_all("areset", 1'b0, 1'b0, 1'b0, 0, 0, 0);
      @(negedge clk_i);
      rst_ni       = 1'b1;
      pe_c_valid_i = 1'b0;
      pe_c_ready_i = 1'b0;
      tick();
      check_all("areset.post", 1'b0, 1'b0, 1'b0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
